// File: rtl/axi4l_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4l_pkg
// Description : Shared types and constants for the register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4l_pkg;

    localparam int RF_SRC_W_MAX = 4;
    localparam int SRC_AXI      = 0;

    typedef logic [RF_SRC_W_MAX-1:0] rf_src_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic int src_width(input int num_hw);
        return $clog2(num_hw + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin one-hot picker, search from ptr_i.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o
);

    localparam logic [PTR_W:0] c_N = (PTR_W + 1)'(N);

    logic             w_found;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            // Wrap modulo N without a divider: ptr_i < N and i < N.
            w_sum = {1'b0, ptr_i} + (PTR_W + 1)'(i);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (en_i && !w_found && req_i[w_idx]) begin
                gnt_o[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/s_axi4l_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : s_axi4l_rf_wr_arbiter
// Description : Shares the register-file write port between the AXI write
//               strobe (always wins) and NUM_HW round-robin/lockable requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module s_axi4l_rf_wr_arbiter
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_HW     = 2,
    parameter int LOCK_MAX   = 16
) (
    input  logic                             i_axi_clock,
    input  logic                             i_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]            i_axi_waddr,
    input  logic [DATA_WIDTH-1:0]            i_axi_wdata,
    input  logic                             i_axi_wvalid,
    input  logic [NUM_HW-1:0]                i_hw_req,
    input  logic [NUM_HW-1:0]                i_hw_lock,
    input  logic [NUM_HW*ADDR_WIDTH-1:0]     i_hw_addr,
    input  logic [NUM_HW*DATA_WIDTH-1:0]     i_hw_data,
    output logic [NUM_HW-1:0]                o_hw_gnt,
    output logic [ADDR_WIDTH-1:0]            o_rf_waddr,
    output logic [DATA_WIDTH-1:0]            o_rf_wdata,
    output logic                             o_rf_wvalid,
    output logic [$clog2(NUM_HW+1)-1:0]      o_rf_src,
    output logic                             o_lock_timeout
);

    localparam int SRC_W = src_width(NUM_HW);
    localparam int IDX_W = (NUM_HW > 1) ? $clog2(NUM_HW) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(LOCK_MAX - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]   rf_waddr_q;
    logic [DATA_WIDTH-1:0]   rf_wdata_q;
    logic                    rf_wvalid_q;
    logic [SRC_W-1:0]        rf_src_q;

    logic [NUM_HW-1:0]       w_owner_mask;
    logic [NUM_HW-1:0]       w_arb_req;
    logic                    w_arb_en;
    logic [NUM_HW-1:0]       w_gnt;
    logic                    w_gnt_any;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic [IDX_W-1:0]        w_gnt_next;
    logic [IDX_W-1:0]        w_owner_next;
    logic                    w_timeout;

    // While locked, only the owner is visible to the arbiter.
    assign w_owner_mask = NUM_HW'(1) << owner_q;
    assign w_arb_req    = (state_q == ST_LOCKED) ? (i_hw_req & w_owner_mask) : i_hw_req;
    assign w_arb_en     = !i_axi_wvalid && i_axi_aresetn;
    assign w_gnt_any    = |w_gnt;

    rr_arbiter #(
        .N     (NUM_HW),
        .PTR_W (IDX_W)
    ) u_rr_arbiter (
        .req_i (w_arb_req),
        .ptr_i (rr_q),
        .en_i  (w_arb_en),
        .gnt_o (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_HW; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx = IDX_W'(k);
            end
        end
    end

    if (NUM_HW == 1) begin : g_rr_single
        assign w_gnt_next   = '0;
        assign w_owner_next = '0;
    end else begin : g_rr_multi
        assign w_gnt_next   = (w_gnt_idx == IDX_W'(NUM_HW - 1)) ? '0 : w_gnt_idx + 1'b1;
        assign w_owner_next = (owner_q   == IDX_W'(NUM_HW - 1)) ? '0 : owner_q + 1'b1;
    end

    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_gnt_any) begin
                    rr_d = w_gnt_next;
                    if (i_hw_lock[w_gnt_idx]) begin
                        state_d = ST_LOCKED;
                        owner_d = w_gnt_idx;
                        cnt_d   = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (cnt_q != c_CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A grant in the timeout cycle is still honoured; only the lock ends.
                if (w_timeout || !i_hw_req[owner_q] ||
                    (w_gnt_any && !i_hw_lock[owner_q])) begin
                    state_d = ST_IDLE;
                    rr_d    = w_owner_next;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_hw_gnt  = w_gnt;
        w_timeout = (state_q == ST_LOCKED) && (cnt_q == c_CNT_MAX);
    end

    assign o_lock_timeout = w_timeout;

    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            rf_wvalid_q <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rf_src_q    <= '0;
        end else begin
            rf_wvalid_q <= i_axi_wvalid || w_gnt_any;
            if (i_axi_wvalid) begin
                rf_waddr_q <= i_axi_waddr;
                rf_wdata_q <= i_axi_wdata;
                rf_src_q   <= SRC_W'(SRC_AXI);
            end else if (w_gnt_any) begin
                rf_waddr_q <= i_hw_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                rf_wdata_q <= i_hw_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                rf_src_q   <= SRC_W'(w_gnt_idx) + SRC_W'(1);
            end
        end
    end

    assign o_rf_wvalid = rf_wvalid_q;
    assign o_rf_waddr  = rf_waddr_q;
    assign o_rf_wdata  = rf_wdata_q;
    assign o_rf_src    = rf_src_q;

endmodule
`default_nettype wire

// File: tb/tb_s_axi4l_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_axi4l_rf_wr_arbiter
// Description : Directed self-checking bench for the register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_axi4l_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        r_rst_n;
    logic [3:0]  r_axi_waddr;
    logic [31:0] r_axi_wdata;
    logic        r_axi_wvalid;
    logic [1:0]  r_hw_req;
    logic [1:0]  r_hw_lock;
    logic [3:0]  r_a0, r_a1;
    logic [31:0] r_d0, r_d1;
    logic [1:0]  w_hw_gnt;
    logic [3:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    logic        w_rf_wvalid;
    logic [1:0]  w_rf_src;
    logic        w_lock_timeout;
    logic [31:0] r_rf_model [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    s_axi4l_rf_wr_arbiter #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32),
        .NUM_HW     (2),
        .LOCK_MAX   (16)
    ) dut (
        .i_axi_clock    (clk),
        .i_axi_aresetn  (r_rst_n),
        .i_axi_waddr    (r_axi_waddr),
        .i_axi_wdata    (r_axi_wdata),
        .i_axi_wvalid   (r_axi_wvalid),
        .i_hw_req       (r_hw_req),
        .i_hw_lock      (r_hw_lock),
        .i_hw_addr      ({r_a1, r_a0}),
        .i_hw_data      ({r_d1, r_d0}),
        .o_hw_gnt       (w_hw_gnt),
        .o_rf_waddr     (w_rf_waddr),
        .o_rf_wdata     (w_rf_wdata),
        .o_rf_wvalid    (w_rf_wvalid),
        .o_rf_src       (w_rf_src),
        .o_lock_timeout (w_lock_timeout)
    );

    // Register-file image built from the write port, sampled mid-cycle.
    always @(negedge clk) begin
        if (w_rf_wvalid) r_rf_model[w_rf_waddr] = w_rf_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cyc(input logic [1:0] exp_gnt, input logic exp_to, input string tag);
        #1;
        chk({tag, "_gnt"}, 64'(w_hw_gnt), 64'(exp_gnt));
        chk({tag, "_to"}, 64'(w_lock_timeout), 64'(exp_to));
        @(negedge clk);
    endtask

    task automatic chk_rf(input string tag, input logic v, input logic [3:0] a,
                          input logic [31:0] d, input logic [1:0] s);
        chk({tag, "_wvalid"}, 64'(w_rf_wvalid), 64'(v));
        chk({tag, "_waddr"},  64'(w_rf_waddr),  64'(a));
        chk({tag, "_wdata"},  64'(w_rf_wdata),  64'(d));
        chk({tag, "_src"},    64'(w_rf_src),    64'(s));
    endtask

    initial begin
        r_rst_n = 1'b0;
        r_axi_waddr = '0; r_axi_wdata = '0; r_axi_wvalid = 1'b0;
        r_hw_req = 2'b11; r_hw_lock = 2'b00;
        r_a0 = 4'h8; r_a1 = 4'h9; r_d0 = 32'h100; r_d1 = 32'h200;
        for (int i = 0; i < 16; i++) r_rf_model[i] = '0;

        #2;
        chk_rf("reset", 1'b0, 4'h0, 32'h0, 2'd0);
        chk("reset_gnt", 64'(w_hw_gnt), 64'h0);
        chk("reset_to", 64'(w_lock_timeout), 64'h0);
        repeat (2) @(negedge clk);
        r_rst_n = 1'b1; r_hw_req = 2'b00;

        // AXI only
        r_axi_wvalid = 1'b1; r_axi_waddr = 4'h3; r_axi_wdata = 32'hDEADBEEF;
        cyc(2'b00, 1'b0, "axi");
        chk_rf("axi", 1'b1, 4'h3, 32'hDEADBEEF, 2'd0);
        r_axi_wvalid = 1'b0;
        cyc(2'b00, 1'b0, "axi_idle");
        chk_rf("axi_hold", 1'b0, 4'h3, 32'hDEADBEEF, 2'd0);

        // Round-robin between two requesters held high
        r_hw_req = 2'b11;
        cyc(2'b01, 1'b0, "rr0"); chk_rf("rr0", 1'b1, 4'h8, 32'h100, 2'd1);
        cyc(2'b10, 1'b0, "rr1"); chk_rf("rr1", 1'b1, 4'h9, 32'h200, 2'd2);
        cyc(2'b01, 1'b0, "rr2"); chk_rf("rr2", 1'b1, 4'h8, 32'h100, 2'd1);
        cyc(2'b10, 1'b0, "rr3"); chk_rf("rr3", 1'b1, 4'h9, 32'h200, 2'd2);

        // Same-address collision: AXI first, hardware value lands last
        r_axi_wvalid = 1'b1; r_axi_waddr = 4'h5; r_axi_wdata = 32'h1;
        r_hw_req = 2'b01; r_a0 = 4'h5; r_d0 = 32'h2;
        cyc(2'b00, 1'b0, "col_axi"); chk_rf("col_axi", 1'b1, 4'h5, 32'h1, 2'd0);
        r_axi_wvalid = 1'b0;
        cyc(2'b01, 1'b0, "col_hw"); chk_rf("col_hw", 1'b1, 4'h5, 32'h2, 2'd1);
        r_hw_req = 2'b00;
        cyc(2'b00, 1'b0, "col_idle");
        chk("col_reg5", 64'(r_rf_model[5]), 64'h2);

        // Lock: pointer is at hw1, so serve hw1 once to bring it back to hw0
        r_hw_req = 2'b10; r_a1 = 4'h2; r_d1 = 32'hB0;
        cyc(2'b10, 1'b0, "pre_lock");
        r_hw_req = 2'b11; r_hw_lock = 2'b01; r_a0 = 4'h1; r_d0 = 32'hA0;
        cyc(2'b01, 1'b0, "lk_w0"); chk_rf("lk_w0", 1'b1, 4'h1, 32'hA0, 2'd1);
        r_d0 = 32'hA1;
        cyc(2'b01, 1'b0, "lk_w1"); chk_rf("lk_w1", 1'b1, 4'h1, 32'hA1, 2'd1);
        r_d0 = 32'hA2; r_hw_lock = 2'b00;
        cyc(2'b01, 1'b0, "lk_w2"); chk_rf("lk_w2", 1'b1, 4'h1, 32'hA2, 2'd1);
        r_hw_req = 2'b10;
        cyc(2'b10, 1'b0, "lk_hw1"); chk_rf("lk_hw1", 1'b1, 4'h2, 32'hB0, 2'd2);

        // Lock timeout: AXI blocks the owner every cycle of the lock
        r_hw_req = 2'b11; r_hw_lock = 2'b01; r_a0 = 4'h7; r_d0 = 32'hC0; r_d1 = 32'hD0;
        cyc(2'b01, 1'b0, "to_lock"); chk_rf("to_lock", 1'b1, 4'h7, 32'hC0, 2'd1);
        r_axi_wvalid = 1'b1; r_axi_waddr = 4'hE;
        for (int i = 0; i < 16; i++) begin
            r_axi_wdata = 32'(i);
            cyc(2'b00, (i == 15), "to_wait");
            chk_rf("to_wait", 1'b1, 4'hE, 32'(i), 2'd0);
        end
        r_axi_wvalid = 1'b0;
        cyc(2'b10, 1'b0, "to_hw1"); chk_rf("to_hw1", 1'b1, 4'h2, 32'hD0, 2'd2);

        // Owner withdraws its request while locked
        r_hw_req = 2'b11; r_hw_lock = 2'b01;
        cyc(2'b01, 1'b0, "wd_lock");
        r_hw_req = 2'b10;
        cyc(2'b00, 1'b0, "wd_drop");
        cyc(2'b10, 1'b0, "wd_hw1");
        r_hw_req = 2'b00;
        cyc(2'b00, 1'b0, "wd_idle");

        // Reset asserted before the accepted write reaches the output
        r_hw_req = 2'b01; r_hw_lock = 2'b01; r_a0 = 4'hC; r_d0 = 32'hEE;
        #1;
        chk("rst_pre_gnt", 64'(w_hw_gnt), 64'h1);
        #2 r_rst_n = 1'b0;
        #1;
        chk("rst_gnt", 64'(w_hw_gnt), 64'h0);
        @(posedge clk); #1;
        chk_rf("rst_mid", 1'b0, 4'h0, 32'h0, 2'd0);
        @(negedge clk);
        r_rst_n = 1'b1;
        r_hw_req = 2'b11; r_hw_lock = 2'b00; r_d0 = 32'h11; r_d1 = 32'h22;
        cyc(2'b01, 1'b0, "post_rst0"); chk_rf("post_rst0", 1'b1, 4'hC, 32'h11, 2'd1);
        cyc(2'b10, 1'b0, "post_rst1"); chk_rf("post_rst1", 1'b1, 4'h2, 32'h22, 2'd2);
        r_hw_req = 2'b00;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
